// File: rtl/bmu_pkg.sv
// Shared definitions for the bit-manipulation unit: the opcode encoding
// and a helper that separates legal opcodes from illegal ones.
package bmu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLT    = 5'd2,
        OP_SLTU   = 5'd3,
        OP_AND    = 5'd4,
        OP_XOR    = 5'd5,
        OP_SLL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_ROL    = 5'd8,
        OP_BEXT   = 5'd9,
        OP_SH3ADD = 5'd10,
        OP_CLZ    = 5'd11,
        OP_CPOP   = 5'd12,
        OP_SEXTH  = 5'd13,
        OP_MIN    = 5'd14,
        OP_ORCB   = 5'd15,
        OP_PACKU  = 5'd16
    } op_e;

    // Highest legal opcode; every encoding above it is reported as an error.
    localparam int OP_LAST = 16;

    function automatic logic op_is_legal(input logic [4:0] op);
        return op <= 5'(OP_LAST);
    endfunction

endpackage

// File: rtl/bmu_pipe_if.sv
// Request/response bus of the BMU pipeline. The issue side drives the
// request half and consumes the result half (master); the BMU is the slave.
interface bmu_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    logic               in_valid;
    logic               in_ready;
    bmu_pkg::op_e       in_op;
    logic [XLEN-1:0]    in_a;
    logic [XLEN-1:0]    in_b;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_result;
    logic               out_error;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_error, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_error, out_tag
    );
endinterface

// File: rtl/bmu_alu.sv
// Combinational bit-manipulation datapath. Computes the result for one
// request; illegal opcodes give a zero result with the error flag set.
module bmu_alu
    import bmu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  op_e             op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            error
);
    localparam int SW = $clog2(XLEN);
    localparam int CW = SW + 1;

    logic [SW-1:0]   shamt;
    logic [CW-1:0]   rol_rsh;
    logic [XLEN-1:0] rol_val;
    logic [CW-1:0]   clz_cnt;
    logic [CW-1:0]   cpop_cnt;
    logic            clz_done;
    logic [XLEN-1:0] orcb_val;

    // Only the low log2(XLEN) bits of b select a shift or bit position.
    assign shamt = b[SW-1:0];

    // A zero rotate shifts right by XLEN, which contributes nothing.
    assign rol_rsh = CW'(XLEN) - CW'(shamt);
    assign rol_val = (a << shamt) | (a >> rol_rsh);

    assign error = !op_is_legal(op);

    // Leading-zero and population counts; an all-zero operand counts as XLEN zeros.
    always_comb begin
        clz_cnt  = CW'(XLEN);
        clz_done = 1'b0;
        cpop_cnt = '0;
        for (int i = XLEN - 1; i >= 0; i--) begin
            if (!clz_done && a[i]) begin
                clz_cnt  = CW'(XLEN - 1 - i);
                clz_done = 1'b1;
            end
            cpop_cnt = cpop_cnt + CW'(a[i]);
        end
    end

    // Each byte saturates to all ones when any of its bits is set.
    always_comb begin
        orcb_val = '0;
        for (int k = 0; k < XLEN / 8; k++) begin
            orcb_val[k*8 +: 8] = {8{|a[k*8 +: 8]}};
        end
    end

    // Opcode decode; anything past the last legal opcode yields zero.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:    result = a + b;
            OP_SUB:    result = a - b;
            OP_SLT:    result = XLEN'($signed(a) < $signed(b));
            OP_SLTU:   result = XLEN'(a < b);
            OP_AND:    result = a & b;
            OP_XOR:    result = a ^ b;
            OP_SLL:    result = a << shamt;
            OP_SRA:    result = $unsigned($signed(a) >>> shamt);
            OP_ROL:    result = rol_val;
            OP_BEXT:   result = XLEN'(a[shamt]);
            OP_SH3ADD: result = (a << 3) + b;
            OP_CLZ:    result = XLEN'(clz_cnt);
            OP_CPOP:   result = XLEN'(cpop_cnt);
            OP_SEXTH:  result = {{(XLEN-16){a[15]}}, a[15:0]};
            OP_MIN:    result = ($signed(b) < $signed(a)) ? b : a;
            OP_ORCB:   result = orcb_val;
            OP_PACKU:  result = {b[XLEN-1:XLEN/2], a[XLEN-1:XLEN/2]};
            default:   result = '0;
        endcase
    end
endmodule

// File: rtl/bmu_pipe.sv
// Pipelined BMU: the ALU result is captured at entry and carried through
// STAGES registers with valid/ready flow control. Empty stages are filled
// from behind, so bubbles collapse while the output is stalled.
module bmu_pipe
    import bmu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic        clk,
    input  logic        rst,
    bmu_pipe_if.slave   bus
);
    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    result;
        logic               error;
        logic [TAG_W-1:0]   tag;
    } stage_t;

    stage_t             stage_q [STAGES];
    stage_t             stage_d [STAGES];
    logic [STAGES-1:0]  adv;
    logic               in_ready;
    logic [XLEN-1:0]    alu_result;
    logic               alu_error;

    bmu_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .op     (bus.in_op),
        .a      (bus.in_a),
        .b      (bus.in_b),
        .result (alu_result),
        .error  (alu_error)
    );

    // A stage may take new contents when it or any stage ahead of it has a
    // hole, or the consumer is taking the head; written flat to avoid a chain.
    always_comb begin
        adv = '0;
        for (int i = 0; i < STAGES; i++) begin
            adv[i] = bus.out_ready;
            for (int j = i; j < STAGES; j++) begin
                if (!stage_q[j].valid) begin
                    adv[i] = 1'b1;
                end
            end
        end
    end

    assign in_ready     = !rst && adv[0];
    assign bus.in_ready = in_ready;

    // Next contents of every stage: load from the one behind when advancing, else hold.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (adv[0]) begin
            stage_d[0].valid  = bus.in_valid && in_ready;
            stage_d[0].result = alu_result;
            stage_d[0].error  = alu_error;
            stage_d[0].tag    = bus.in_tag;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (adv[i]) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // Stage registers; reset discards everything in flight and zeroes the outputs.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
            if (rst) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign bus.out_valid  = stage_q[STAGES-1].valid;
    assign bus.out_result = stage_q[STAGES-1].result;
    assign bus.out_error  = stage_q[STAGES-1].error;
    assign bus.out_tag    = stage_q[STAGES-1].tag;
endmodule

// File: tb/tb_bmu_pipe.sv
// Bench for bmu_pipe: one instance at XLEN=32/STAGES=2 and one at
// XLEN=64/STAGES=4. Stimulus pushes hand-computed expectations into a
// per-instance queue; monitors pop and compare on every output handshake.
module tb_bmu_pipe;
    import bmu_pkg::*;

    typedef struct {
        logic [63:0] result;
        logic        error;
        logic [3:0]  tag;
    } exp_t;

    logic clk;
    logic rst_a;
    logic rst_b;

    int   checkCount;
    int   passCount;
    exp_t sb_a[$];
    exp_t sb_b[$];

    bmu_pipe_if #(.XLEN(32), .TAG_W(4)) if_a ();
    bmu_pipe_if #(.XLEN(64), .TAG_W(4)) if_b ();

    bmu_pipe #(.XLEN(32), .STAGES(2), .TAG_W(4)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (if_a)
    );

    bmu_pipe #(.XLEN(64), .STAGES(4), .TAG_W(4)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (if_b)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Present one request, wait for it to be accepted, and queue its expectation.
    task automatic applyStimulus(input int dut, input op_e op, input logic [63:0] a,
                                 input logic [63:0] b, input logic [3:0] tag,
                                 input logic [63:0] exp_res, input logic exp_err,
                                 output int waits);
        exp_t e;
        logic rdy;
        e.result = exp_res;
        e.error  = exp_err;
        e.tag    = tag;
        if (dut == 0) begin
            if_a.in_valid = 1'b1;
            if_a.in_op    = op;
            if_a.in_a     = a[31:0];
            if_a.in_b     = b[31:0];
            if_a.in_tag   = tag;
        end else begin
            if_b.in_valid = 1'b1;
            if_b.in_op    = op;
            if_b.in_a     = a;
            if_b.in_b     = b;
            if_b.in_tag   = tag;
        end
        waits = 0;
        forever begin
            @(negedge clk);
            rdy = (dut == 0) ? if_a.in_ready : if_b.in_ready;
            @(posedge clk);
            if (rdy) begin
                if (dut == 0) sb_a.push_back(e);
                else          sb_b.push_back(e);
                break;
            end
            waits++;
            if (waits > 50) begin
                checkCount++;
                $display("[TB] FAIL accept_timeout: in_ready 0 for %0d cycles, expected 1", waits);
                break;
            end
        end
        #1;
        if (dut == 0) if_a.in_valid = 1'b0;
        else          if_b.in_valid = 1'b0;
    endtask

    // Count negedges after the accept edge until out_valid rises.
    task automatic checkLatency(input int dut, input int expected);
        int   k;
        logic v;
        k = 0;
        forever begin
            @(negedge clk);
            v = (dut == 0) ? if_a.out_valid : if_b.out_valid;
            if (v) break;
            k++;
            if (k > 20) break;
        end
        checkOutput((dut == 0) ? "a_latency" : "b_latency", 64'(k), 64'(expected));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor for the 32-bit instance.
    always @(negedge clk) begin
        if (if_a.out_valid && if_a.out_ready) begin
            if (sb_a.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL a_unexpected: result 0x%0h tag %0d with nothing expected",
                         if_a.out_result, if_a.out_tag);
            end else begin
                exp_t e;
                e = sb_a.pop_front();
                checkOutput("a_result", 64'(if_a.out_result), e.result);
                checkOutput("a_error", 64'(if_a.out_error), 64'(e.error));
                checkOutput("a_tag", 64'(if_a.out_tag), 64'(e.tag));
            end
        end
    end

    // Scoreboard monitor for the 64-bit instance.
    always @(negedge clk) begin
        if (if_b.out_valid && if_b.out_ready) begin
            if (sb_b.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL b_unexpected: result 0x%0h tag %0d with nothing expected",
                         if_b.out_result, if_b.out_tag);
            end else begin
                exp_t e;
                e = sb_b.pop_front();
                checkOutput("b_result", if_b.out_result, e.result);
                checkOutput("b_error", 64'(if_b.out_error), 64'(e.error));
                checkOutput("b_tag", 64'(if_b.out_tag), 64'(e.tag));
            end
        end
    end

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    // Directed sequence.
    initial begin
        int w;
        checkCount     = 0;
        passCount      = 0;
        rst_a          = 1'b1;
        rst_b          = 1'b1;
        if_a.in_valid  = 1'b0;
        if_a.in_op     = OP_ADD;
        if_a.in_a      = '0;
        if_a.in_b      = '0;
        if_a.in_tag    = '0;
        if_a.out_ready = 1'b1;
        if_b.in_valid  = 1'b0;
        if_b.in_op     = OP_ADD;
        if_b.in_a      = '0;
        if_b.in_b      = '0;
        if_b.in_tag    = '0;
        if_b.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        checkOutput("a_reset_out_valid", 64'(if_a.out_valid), 64'd0);
        checkOutput("a_reset_in_ready", 64'(if_a.in_ready), 64'd1);
        checkOutput("b_reset_out_valid", 64'(if_b.out_valid), 64'd0);
        checkOutput("b_reset_in_ready", 64'(if_b.in_ready), 64'd1);
        idle(1);

        $display("[TB] ADD latency");
        applyStimulus(0, OP_ADD, 64'h7FFF_FFFF, 64'h1, 4'd3, 64'h8000_0000, 1'b0, w);
        checkLatency(0, 1);
        idle(3);

        $display("[TB] directed opcodes, back to back");
        applyStimulus(0, OP_CLZ,    64'h0000_0000, 64'h0, 4'd1, 64'd32,         1'b0, w);
        applyStimulus(0, OP_CLZ,    64'h0001_0000, 64'h0, 4'd2, 64'd15,         1'b0, w);
        applyStimulus(0, OP_CPOP,   64'hF0F0_F0F0, 64'h0, 4'd3, 64'd16,         1'b0, w);
        applyStimulus(0, OP_ORCB,   64'h0010_0001, 64'h0, 4'd4, 64'h00FF_00FF,  1'b0, w);
        applyStimulus(0, OP_SEXTH,  64'h0000_8001, 64'h0, 4'd5, 64'hFFFF_8001,  1'b0, w);
        applyStimulus(0, OP_SRA,    64'h8000_0000, 64'h24, 4'd6, 64'hF800_0000, 1'b0, w);
        applyStimulus(0, op_e'(5'd20), 64'h1234_5678, 64'h1, 4'd9, 64'h0,       1'b1, w);
        applyStimulus(0, OP_SUB,    64'h0000_0000, 64'h1, 4'd10, 64'hFFFF_FFFF, 1'b0, w);
        applyStimulus(0, OP_SLT,    64'hFFFF_FFFF, 64'h1, 4'd11, 64'd1,         1'b0, w);
        applyStimulus(0, OP_SLTU,   64'hFFFF_FFFF, 64'h1, 4'd12, 64'd0,         1'b0, w);
        applyStimulus(0, OP_SLT,    64'h5, 64'h5, 4'd13, 64'd0,                 1'b0, w);
        applyStimulus(0, OP_MIN,    64'h5, 64'h5, 4'd14, 64'd5,                 1'b0, w);
        applyStimulus(0, OP_MIN,    64'hFFFF_FFFE, 64'h3, 4'd15, 64'hFFFF_FFFE, 1'b0, w);
        applyStimulus(0, OP_PACKU,  64'h1234_5678, 64'h9ABC_DEF0, 4'd0, 64'h9ABC_1234, 1'b0, w);
        applyStimulus(0, OP_BEXT,   64'h0000_0100, 64'h8, 4'd1, 64'd1,          1'b0, w);
        applyStimulus(0, OP_SH3ADD, 64'h2, 64'h5, 4'd2, 64'h15,                 1'b0, w);
        applyStimulus(0, OP_ROL,    64'h8000_0001, 64'h1, 4'd3, 64'h3,          1'b0, w);
        applyStimulus(0, OP_SLL,    64'h1, 64'h3F, 4'd4, 64'h8000_0000,         1'b0, w);
        applyStimulus(0, OP_AND,    64'hFF00_FF00, 64'h0FF0_0FF0, 4'd5, 64'h0F00_0F00, 1'b0, w);
        applyStimulus(0, OP_XOR,    64'hFFFF_0000, 64'h0F0F_0F0F, 4'd6, 64'hF0F0_0F0F, 1'b0, w);
        idle(5);

        $display("[TB] backpressure");
        if_a.out_ready = 1'b0;
        fork
            begin
                applyStimulus(0, OP_ADD, 64'd10, 64'd1, 4'd1, 64'd11,  1'b0, w);
                applyStimulus(0, OP_ADD, 64'd20, 64'd2, 4'd2, 64'd22,  1'b0, w);
                applyStimulus(0, OP_XOR, 64'hF0, 64'h0F, 4'd3, 64'hFF, 1'b0, w);
                applyStimulus(0, OP_AND, 64'hF0, 64'h3C, 4'd4, 64'h30, 1'b0, w);
            end
            begin
                @(negedge clk);
                checkOutput("bp_ready_empty", 64'(if_a.in_ready), 64'd1);
                @(posedge clk);
                @(negedge clk);
                checkOutput("bp_ready_one_held", 64'(if_a.in_ready), 64'd1);
                @(posedge clk);
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    checkOutput("bp_ready_full", 64'(if_a.in_ready), 64'd0);
                    checkOutput("bp_stall_valid", 64'(if_a.out_valid), 64'd1);
                    checkOutput("bp_stall_tag", 64'(if_a.out_tag), 64'd1);
                    checkOutput("bp_stall_result", 64'(if_a.out_result), 64'd11);
                    checkOutput("bp_stall_error", 64'(if_a.out_error), 64'd0);
                    @(posedge clk);
                end
                #1;
                if_a.out_ready = 1'b1;
            end
        join
        idle(6);

        $display("[TB] reset with requests in flight");
        if_a.out_ready = 1'b0;
        applyStimulus(0, OP_ADD, 64'h100, 64'h23, 4'd5, 64'h123, 1'b0, w);
        applyStimulus(0, OP_XOR, 64'hFF, 64'h0F, 4'd6, 64'hF0, 1'b0, w);
        sb_a.delete();
        rst_a         = 1'b1;
        if_a.in_valid = 1'b1;
        if_a.in_op    = OP_ADD;
        if_a.in_a     = 32'd1;
        if_a.in_b     = 32'd1;
        if_a.in_tag   = 4'd7;
        @(negedge clk);
        checkOutput("rst_in_ready_low", 64'(if_a.in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_a         = 1'b0;
        if_a.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", 64'(if_a.out_valid), 64'd0);
        checkOutput("rst_out_result", 64'(if_a.out_result), 64'd0);
        checkOutput("rst_out_error", 64'(if_a.out_error), 64'd0);
        checkOutput("rst_out_tag", 64'(if_a.out_tag), 64'd0);
        checkOutput("rst_in_ready_release", 64'(if_a.in_ready), 64'd1);
        @(posedge clk);
        #1;
        if_a.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("rst_stays_empty", 64'(if_a.out_valid), 64'd0);
        end
        idle(1);

        $display("[TB] 64-bit, 4-stage instance");
        applyStimulus(1, OP_ROL, 64'h8000_0000_0000_0001, 64'h1, 4'd8,
                      64'h0000_0000_0000_0003, 1'b0, w);
        checkLatency(1, 3);
        idle(6);
        applyStimulus(1, OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 4'd1, 64'h1, 1'b0, w);
        checkOutput("b_accept_stall", 64'(w), 64'd0);
        applyStimulus(1, OP_CLZ, 64'h1, 64'h0, 4'd2, 64'd63, 1'b0, w);
        checkOutput("b_accept_stall", 64'(w), 64'd0);
        applyStimulus(1, OP_CPOP, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 4'd3, 64'd64, 1'b0, w);
        checkOutput("b_accept_stall", 64'(w), 64'd0);
        applyStimulus(1, OP_PACKU, 64'h1111_1111_2222_2222, 64'h3333_3333_4444_4444, 4'd4,
                      64'h3333_3333_1111_1111, 1'b0, w);
        checkOutput("b_accept_stall", 64'(w), 64'd0);
        applyStimulus(1, OP_SEXTH, 64'h8000, 64'h0, 4'd5, 64'hFFFF_FFFF_FFFF_8000, 1'b0, w);
        checkOutput("b_accept_stall", 64'(w), 64'd0);
        applyStimulus(1, op_e'(5'd31), 64'h5, 64'h5, 4'd6, 64'h0, 1'b1, w);
        checkOutput("b_accept_stall", 64'(w), 64'd0);
        idle(10);

        checkOutput("a_drained", 64'(sb_a.size()), 64'd0);
        checkOutput("b_drained", 64'(sb_b.size()), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
